// File: rtl/dct8x8_pkg.sv
// Shared constants for the 8x8 DCT datapath: block dimension and the
// width of a row/column index inside one block.
package dct8x8_pkg;

  // Rows and columns per DCT block.
  localparam int DCT_N = 8;

  // Bits needed to address one row or one column of a block.
  localparam int DCT_IDX_W = $clog2(DCT_N);

endpackage

// File: rtl/dct8x8_tbuf_ctrl.sv
// Ping-pong controller for the DCT transpose buffer. Rows from the row
// stage are written into one bank while columns of the previously
// completed block are read from the other bank toward the column stage.
// Read data comes from a synchronous RAM with one cycle of latency, so
// rd_vld_o/rd_last_o form a one-deep output register stage that can hold
// under backpressure without disturbing the RAM output.
module dct8x8_tbuf_ctrl
  import dct8x8_pkg::*;
#(
  parameter int N     = DCT_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld_i,
  output logic             wr_rdy_o,
  output logic             wr_en_o,
  output logic             wr_bank_o,
  output logic [IDX_W-1:0] wr_row_o,
  output logic             rd_en_o,
  output logic             rd_bank_o,
  output logic [IDX_W-1:0] rd_col_o,
  output logic             rd_vld_o,
  output logic             rd_last_o,
  input  logic             rd_rdy_i,
  output logic             blk_done_o,
  output logic [1:0]       bank_full_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic             rbank_q, rbank_d;
  logic [IDX_W-1:0] wrow_q, wrow_d;
  logic [IDX_W-1:0] rcol_q, rcol_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_last_q, rd_last_d;

  logic             wrRdy;
  logic             wrEn;
  logic             rdEn;
  logic             blkDone;

  // Handshake strobes; all forced low while reset is held so the buffer
  // and the column stage see no activity during reset.
  always_comb begin
    wrRdy   = 1'b0;
    wrEn    = 1'b0;
    rdEn    = 1'b0;
    blkDone = 1'b0;
    if (!rst) begin
      wrRdy   = !full_q[wbank_q];
      wrEn    = wr_vld_i & wrRdy;
      rdEn    = full_q[rbank_q] & (!rd_vld_q | rd_rdy_i);
      blkDone = rd_vld_q & rd_rdy_i & rd_last_q;
    end
  end

  // Next-state for bank flags, write/read pointers and the output stage.
  // A full-set and a full-clear in the same cycle always hit different
  // banks (writes need an empty bank, reads a full one), so both apply.
  always_comb begin
    full_d    = full_q;
    wbank_d   = wbank_q;
    wrow_d    = wrow_q;
    rbank_d   = rbank_q;
    rcol_d    = rcol_q;
    rd_vld_d  = rdEn | (rd_vld_q & !rd_rdy_i);
    rd_last_d = rd_last_q;

    if (wrEn) begin
      if (wrow_q == LastIdx) begin
        full_d[wbank_q] = 1'b1;
        wrow_d          = '0;
        wbank_d         = !wbank_q;
      end else begin
        wrow_d = wrow_q + IDX_W'(1);
      end
    end

    if (rdEn) begin
      rd_last_d = (rcol_q == LastIdx);
      if (rcol_q == LastIdx) begin
        full_d[rbank_q] = 1'b0;
        rcol_d          = '0;
        rbank_d         = !rbank_q;
      end else begin
        rcol_d = rcol_q + IDX_W'(1);
      end
    end
  end

  // State register; reset discards any partially written or read block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 2'b00;
      wbank_q   <= 1'b0;
      wrow_q    <= '0;
      rbank_q   <= 1'b0;
      rcol_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wbank_q   <= wbank_d;
      wrow_q    <= wrow_d;
      rbank_q   <= rbank_d;
      rcol_q    <= rcol_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
    end
  end

  assign wr_rdy_o    = wrRdy;
  assign wr_en_o     = wrEn;
  assign wr_bank_o   = wbank_q;
  assign wr_row_o    = wrow_q;
  assign rd_en_o     = rdEn;
  assign rd_bank_o   = rbank_q;
  assign rd_col_o    = rcol_q;
  assign rd_vld_o    = rd_vld_q;
  assign rd_last_o   = rd_last_q;
  assign blk_done_o  = blkDone;
  assign bank_full_o = full_q;

endmodule

// File: tb/tb_dct8x8_tbuf_ctrl.sv
// Scoreboard bench for the transpose-buffer controller. The driver keeps
// a block-level model (rows written, columns issued, beats accepted) and
// pushes expected responses into queues; a separate monitor pops them
// whenever the DUT presents a strobe and compares.
module tb_dct8x8_tbuf_ctrl;
  import dct8x8_pkg::*;

  localparam int N = DCT_N;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_vld_i = 1'b0;
  logic                 rd_rdy_i = 1'b0;
  logic                 wr_rdy_o, wr_en_o, wr_bank_o;
  logic [DCT_IDX_W-1:0] wr_row_o;
  logic                 rd_en_o, rd_bank_o;
  logic [DCT_IDX_W-1:0] rd_col_o;
  logic                 rd_vld_o, rd_last_o, blk_done_o;
  logic [1:0]           bank_full_o;

  dct8x8_tbuf_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wr_vld_i   (wr_vld_i),
    .wr_rdy_o   (wr_rdy_o),
    .wr_en_o    (wr_en_o),
    .wr_bank_o  (wr_bank_o),
    .wr_row_o   (wr_row_o),
    .rd_en_o    (rd_en_o),
    .rd_bank_o  (rd_bank_o),
    .rd_col_o   (rd_col_o),
    .rd_vld_o   (rd_vld_o),
    .rd_last_o  (rd_last_o),
    .rd_rdy_i   (rd_rdy_i),
    .blk_done_o (blk_done_o),
    .bank_full_o(bank_full_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    bit       wrRdy;
    bit       wrEn;
    bit       rdEn;
    bit       rdVld;
    bit       blkDone;
    bit [1:0] full;
  } cyc_t;

  typedef struct {
    bit bank;
    int idx;
  } addr_t;

  cyc_t  cycQ[$];
  addr_t wrQ[$];
  addr_t rdQ[$];
  bit    accQ[$];

  int nCmp = 0;
  int nBad = 0;
  int doneCnt = 0;
  int issueCnt = 0;

  // Block-level model state: totals since the last reset.
  int wrCount = 0;
  int rdCount = 0;
  int accCount = 0;
  int outst = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the model's expectations for it.
  task automatic applyStimulus(input bit vld, input bit rdy, input bit rstIn);
    cyc_t e;
    addr_t a;
    int blkWr, blkIss, fullCnt;
    bit wrHs, rdIss, acc;
    @(posedge clk);
    #1;
    rst      = rstIn;
    wr_vld_i = vld;
    rd_rdy_i = rdy;
    e = '{default: 0};
    if (rstIn) begin
      wrQ.delete();
      rdQ.delete();
      accQ.delete();
      wrCount = 0;
      rdCount = 0;
      accCount = 0;
      outst = 0;
      cycQ.push_back(e);
      return;
    end
    blkWr   = wrCount / N;
    blkIss  = rdCount / N;
    fullCnt = blkWr - blkIss;
    for (int k = blkIss; k < blkWr; k++) e.full[k % 2] = 1'b1;
    e.wrRdy = (fullCnt < 2);
    wrHs    = vld && e.wrRdy;
    e.wrEn  = wrHs;
    e.rdVld = (outst == 1);
    rdIss   = (fullCnt > 0) && (!e.rdVld || rdy);
    e.rdEn  = rdIss;
    acc     = e.rdVld && rdy;
    e.blkDone = acc && ((accCount % N) == N - 1);
    cycQ.push_back(e);
    if (wrHs) begin
      a.bank = ((wrCount / N) % 2) == 1;
      a.idx  = wrCount % N;
      wrQ.push_back(a);
      wrCount++;
    end
    if (rdIss) begin
      a.bank = ((rdCount / N) % 2) == 1;
      a.idx  = rdCount % N;
      rdQ.push_back(a);
      rdCount++;
    end
    if (acc) begin
      accQ.push_back((accCount % N) == N - 1);
      accCount++;
    end
    outst = outst + (rdIss ? 1 : 0) - (acc ? 1 : 0);
  endtask

  // Monitor: compares every cycle's strobes and pops address/last
  // expectations whenever the DUT issues a write, read or accepted beat.
  always @(negedge clk) begin
    cyc_t e;
    addr_t a;
    bit l;
    if (cycQ.size() > 0) begin
      e = cycQ.pop_front();
      checkOutput("wr_rdy", int'(wr_rdy_o), int'(e.wrRdy));
      checkOutput("wr_en", int'(wr_en_o), int'(e.wrEn));
      checkOutput("rd_en", int'(rd_en_o), int'(e.rdEn));
      checkOutput("rd_vld", int'(rd_vld_o), int'(e.rdVld));
      checkOutput("blk_done", int'(blk_done_o), int'(e.blkDone));
      checkOutput("bank_full", int'(bank_full_o), int'(e.full));
      if (wr_en_o) begin
        if (wrQ.size() == 0) checkOutput("wr_unexpected", 1, 0);
        else begin
          a = wrQ.pop_front();
          checkOutput("wr_bank", int'(wr_bank_o), int'(a.bank));
          checkOutput("wr_row", int'(wr_row_o), a.idx);
        end
      end
      if (rd_en_o) begin
        issueCnt++;
        if (rdQ.size() == 0) checkOutput("rd_unexpected", 1, 0);
        else begin
          a = rdQ.pop_front();
          checkOutput("rd_bank", int'(rd_bank_o), int'(a.bank));
          checkOutput("rd_col", int'(rd_col_o), a.idx);
        end
      end
      if (rd_vld_o && rd_rdy_i) begin
        if (accQ.size() == 0) checkOutput("acc_unexpected", 1, 0);
        else begin
          l = accQ.pop_front();
          checkOutput("rd_last", int'(rd_last_o), int'(l));
        end
      end
      if (blk_done_o) doneCnt++;
    end
  end

  // Directed phases followed by random backpressure and a mid-block reset.
  initial begin
    int d0, i0, start, cyc;
    repeat (3) applyStimulus(0, 0, 1);

    $display("[TB] single block");
    repeat (8) applyStimulus(1, 1, 0);
    repeat (12) applyStimulus(0, 1, 0);

    $display("[TB] streaming 4 blocks");
    d0 = doneCnt;
    i0 = issueCnt;
    repeat (32) applyStimulus(1, 1, 0);
    repeat (12) applyStimulus(0, 1, 0);
    checkOutput("stream_done_cnt", doneCnt - d0, 4);
    checkOutput("stream_issue_cnt", issueCnt - i0, 32);

    $display("[TB] output stall");
    repeat (20) applyStimulus(1, 0, 0);
    repeat (30) applyStimulus(1, 1, 0);
    repeat (20) applyStimulus(0, 1, 0);

    $display("[TB] random backpressure");
    start = wrCount;
    cyc = 0;
    while ((wrCount - start) < 20 * N && cyc < 5000) begin
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 0);
      cyc++;
    end
    if (cyc >= 5000) checkOutput("random_timeout", cyc, 0);
    repeat (40) applyStimulus(0, 1, 0);

    $display("[TB] reset mid-block");
    repeat (2) applyStimulus(0, 0, 1);
    repeat (11) applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    repeat (2) applyStimulus(0, 1, 1);
    repeat (8) applyStimulus(1, 1, 0);
    repeat (20) applyStimulus(0, 1, 0);

    @(negedge clk);
    #1;
    checkOutput("wrQ_empty", wrQ.size(), 0);
    checkOutput("rdQ_empty", rdQ.size(), 0);
    checkOutput("accQ_empty", accQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
